// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1:2 word demultiplexer.
// Optional statistics are compiled in with the DEMUX2_STATS_EN macro (see demux2_32_buf).
package demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;

  // Values of in_sel that pick each destination.
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // Ceiling log2 used to size FIFO pointers (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux2_32_buf_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible combinationally on
// o_head whenever the FIFO is not empty. Pushes while full and pops while empty
// are dropped internally, so callers may present raw requests.
module fifo_fwft
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_push_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2(DEPTH):0]   o_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally; count tracks occupancy (push+pop leaves it unchanged).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux2_32_buf.sv
// Buffered 1:2 demultiplexer: each input word is steered by in_sel into one of
// two independent FWFT FIFOs, each with its own output handshake.
// Build option: define DEMUX2_STATS_EN to add saturating pop/stall counters.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
// in_ready = ~full[in_sel] only (never depends on outN_ready, so a full FIFO
// refuses a push even while it is being popped); outN_valid = FIFO N not empty.
// outN_data is forced to 0 whenever outN_valid is 0.
module demux2_32_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready
`ifdef DEMUX2_STATS_EN
  ,
  output logic [15:0]       stat0_cnt,
  output logic [15:0]       stat1_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW = clog2(DEPTH) + 1;

  logic              w_push;
  logic              w_push0;
  logic              w_push1;
  logic              w_pop0;
  logic              w_pop1;
  logic              w_full0;
  logic              w_full1;
  logic              w_empty0;
  logic              w_empty1;
  logic [DATA_W-1:0] w_head0;
  logic [DATA_W-1:0] w_head1;
  logic [CW-1:0]     w_count0;
  logic [CW-1:0]     w_count1;

  assign in_ready   = (in_sel == SEL_OUT1) ? ~w_full1 : ~w_full0;
  assign w_push     = in_valid & in_ready;
  assign w_push0    = w_push & (in_sel == SEL_OUT0);
  assign w_push1    = w_push & (in_sel == SEL_OUT1);

  assign out0_valid = ~w_empty0;
  assign out1_valid = ~w_empty1;
  assign out0_data  = out0_valid ? w_head0 : '0;
  assign out1_data  = out1_valid ? w_head1 : '0;
  assign w_pop0     = out0_valid & out0_ready;
  assign w_pop1     = out1_valid & out1_ready;

  fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push0),
    .i_push_data (in_data),
    .i_pop       (w_pop0),
    .o_head      (w_head0),
    .o_full      (w_full0),
    .o_empty     (w_empty0),
    .o_count     (w_count0)
  );

  fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push1),
    .i_push_data (in_data),
    .i_pop       (w_pop1),
    .o_head      (w_head1),
    .o_full      (w_full1),
    .o_empty     (w_empty1),
    .o_count     (w_count1)
  );

  // Occupancy sanity: neither FIFO may ever hold more than DEPTH words.
  always_comb begin
    if (!rst) begin
      assert (w_count0 <= CW'(DEPTH));
      assert (w_count1 <= CW'(DEPTH));
    end
  end

`ifdef DEMUX2_STATS_EN
  logic        w_stall;
  logic [15:0] r_stat0_cnt;
  logic [15:0] r_stat1_cnt;
  logic [15:0] r_stall_cnt;

  assign w_stall   = in_valid & ~in_ready;
  assign stat0_cnt = r_stat0_cnt;
  assign stat1_cnt = r_stat1_cnt;
  assign stall_cnt = r_stall_cnt;

  // Saturating counters of completed pops per output and of stalled input cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat0_cnt <= '0;
      r_stat1_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop0 && (r_stat0_cnt != 16'hFFFF))  r_stat0_cnt <= r_stat0_cnt + 1'b1;
      if (w_pop1 && (r_stat1_cnt != 16'hFFFF))  r_stat1_cnt <= r_stat1_cnt + 1'b1;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/demux2_32_buf.md
Name: demux2_32_buf

Overview:
- Buffered 1:2 demultiplexer for 32-bit words; the routing counterpart of the 2:1 select muxes used throughout the datapath.
- Takes one valid/ready input stream and steers each word, by a per-word select bit, into one of two independent output FIFOs.
- Each output has its own valid/ready handshake, so one stalled consumer never blocks words bound for the other.
- Used between the load/store unit and its two consumers: the writeback path (out0) and the MMIO/peripheral port (out1).

Parameters:
- DATA_W, 32, word width of input and both outputs.
- DEPTH, 2, entries per output FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  word to route.
- in_sel  input  1  destination: 0 = out0, 1 = out1; meaningful only while in_valid=1.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept the presented word.
- out0_data  output  DATA_W  head word of FIFO 0.
- out0_valid  output  1  FIFO 0 not empty.
- out0_ready  input  1  consumer 0 takes the head word.
- out1_data  output  DATA_W  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 not empty.
- out1_ready  input  1  consumer 1 takes the head word.

Behaviour:
- One clock; reset is synchronous and active-high; all state changes on the rising edge of clk.
- Reset: both read/write pointers and occupancy counts go to 0, so out0_valid=out1_valid=0 and in_ready=1 in the cycle after rst. Storage array is not reset.
- Reset mid-operation: all buffered words are discarded; a handshake coinciding with rst=1 is ignored.
- outN_data is forced to 0 while outN_valid=0, so it reads 0 out of reset.
- in_ready = ~full[in_sel], combinational.
  - It depends only on the FIFO selected by in_sel, never on the other FIFO and never on outN_ready.
- Push: in_valid & in_ready at an edge writes in_data into FIFO[in_sel] at wr_ptr, then increments wr_ptr (mod DEPTH) and count.
- Pop: outN_valid & outN_ready at an edge increments rd_ptr[N] (mod DEPTH) and decrements count[N].
- First-word fall-through: outN_data is the array entry at rd_ptr[N], read combinationally.
  - Latency: a word pushed at edge k is visible on outN at cycle k+1, so minimum in->out latency is 1 cycle.
- Push and pop on the same FIFO in one cycle, not full: both occur and the count is unchanged.
- Full FIFO with a simultaneous pop: the push is still refused (in_ready=0).
  - This breaks the ready->ready combinational path, so at most DEPTH words are accepted per DEPTH-cycle burst when the consumer drains every cycle.
- A push to one FIFO and a pop from the other in the same cycle are fully independent.
- Empty FIFO: outN_valid=0; outN_ready is ignored and no underflow occurs.
- Ordering: words are delivered in order per output; there is no ordering guarantee between out0 and out1.
- Counts are clog2(DEPTH)+1 bits wide; full when count==DEPTH, empty when count==0. Pointers wrap naturally at clog2(DEPTH) bits.
- The source holds in_data/in_sel stable while in_valid=1 & in_ready=0. The block samples in_sel only at the handshake edge.

Optional Feature:
- Macro: DEMUX2_STATS_EN.
- Defined:
  - Adds outputs stat0_cnt[15:0] and stat1_cnt[15:0], each counting completed pops on its output.
  - Counters saturate at 16'hFFFF and are cleared by rst.
  - Adds output stall_cnt[15:0], counting cycles with in_valid=1 & in_ready=0; it also saturates and is cleared by rst.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Package demux_pkg holds DATA_W_DEF=32, DEPTH_DEF=2, the SEL_OUT0/SEL_OUT1 select constants, and a clog2 function.
- Sub-module fifo_fwft (parameters DATA_W, DEPTH) implements one first-word-fall-through FIFO with push, pop, full, empty and count.
  - demux2_32_buf instantiates it twice and adds the select/ready steering, output zero-gating and the optional stats.

Test Plan:
- Reset then idle -> out0_valid=out1_valid=0, out0_data=out1_data=0, in_ready=1. Assert rst mid-burst with 2 words buffered -> both outputs empty on the next cycle.
- Push 0xDEADBEEF (sel=0) then 0x12345678 (sel=1), both consumers ready -> each word appears on its own output exactly one cycle after its handshake; nothing appears on the other output.
- DEPTH=2, out0_ready=0, push 0xA0, 0xA1, 0xA2 to sel=0 -> in_ready=0 after two pushes, with 0xA0 and 0xA1 held. Switch in_sel=1 -> in_ready=1 and 0xB0 is accepted into FIFO 1.
- FIFO 0 full with out0_ready=1 and a push to sel=0 in the same cycle -> pop occurs, push refused, count becomes 1. Next cycle the push is accepted.
- FIFO 0 holding 1 word, simultaneous push and pop on sel=0 -> count stays 1. Stream 8 words 0x0..0x7 continuously -> out0 delivers 0x0..0x7 in order across pointer wrap.
- With DEMUX2_STATS_EN: after 3 pops on out0, 1 pop on out1 and 2 stalled cycles -> stat0_cnt=3, stat1_cnt=1, stall_cnt=2. Force 70000 pops -> stat0_cnt holds at 0xFFFF.
